// File: rtl/imm_gen_pkg.sv
// Shared types and default field widths for the immediate generator.
package imm_gen_pkg;

  // Instruction format carried on sel
  typedef enum logic [1:0] {
    FMT_AOI = 2'b00,
    FMT_BR  = 2'b01,
    FMT_JMP = 2'b10,
    FMT_PFX = 2'b11
  } fmt_e;

  // Prefix tracking state
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Default field widths
  localparam int DEF_DW = 16;
  localparam int DEF_AW = 4;
  localparam int DEF_BW = 8;
  localparam int DEF_JW = 12;

  // Widest of three field widths; sizes the common alignment bus
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/imm_ext.sv
// Combinational extend/truncate unit: IW-bit input to DW-bit output.
// Wider inputs keep their low DW bits; narrower inputs are sign- or
// zero-extended according to sz.
module imm_ext #(
  parameter int IW = 24,
  parameter int DW = 16
) (
  input  logic [IW-1:0] din,
  input  logic          sz,
  output logic [DW-1:0] dout
);

  generate
    if (IW >= DW) begin : g_trunc
      // Truncation: upper bits and sz play no part in the result
      logic unused_bits;
      assign unused_bits = sz ^ (^din[IW-1:DW-1]);
      assign dout        = din[DW-1:0];
    end else begin : g_ext
      // Extension: replicate the MSB only when sign-extending
      assign dout = {{(DW-IW){sz & din[IW-1]}}, din};
    end
  endgenerate

endmodule

// File: rtl/imm_gen.sv
// Immediate generator with a one-deep prefix register.
// Non-prefix instructions produce a registered, extended immediate one
// cycle after en; a prefix instruction arms a JW-bit payload that is
// concatenated above the next instruction's field.
// Optional build macro: IMM_GEN_BR_SCALE_EN -- scales branch results by 2.
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int BW = DEF_BW,
  parameter int JW = DEF_JW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          flush,
  input  logic [1:0]    sel,
  input  logic          sz,
  input  logic [AW-1:0] f_aoi,
  input  logic [BW-1:0] f_br,
  input  logic [JW-1:0] f_jmp,
  output logic [DW-1:0] imm,
  output logic          imm_vld,
  output logic          pfx_active
);

  // Alignment bus fits a prefix above the widest field, so every
  // format/prefix combination passes through a single extend unit.
  localparam int FW = max3(AW, BW, JW);
  localparam int CW = JW + FW;

  fmt_e          fmt;
  state_e        state_reg;
  logic [JW-1:0] pfx_reg;
  logic [DW-1:0] imm_reg;
  logic          vld_reg;
  logic          armed;
  logic [CW-1:0] aligned_next;
  logic [DW-1:0] ext_next;
  logic [DW-1:0] imm_next;

  assign fmt   = fmt_e'(sel);
  assign armed = (state_reg == ST_ARMED);

  // Place the selected field (and the armed prefix above it) on the
  // alignment bus, filling upper bits with the effective sign.
  always_comb begin
    aligned_next = '0;
    case (fmt)
      FMT_AOI: begin
        if (armed) begin
          aligned_next                = {CW{sz & pfx_reg[JW-1]}};
          aligned_next[AW-1:0]        = f_aoi;
          aligned_next[JW+AW-1:AW]    = pfx_reg;
        end else begin
          aligned_next                = {CW{sz & f_aoi[AW-1]}};
          aligned_next[AW-1:0]        = f_aoi;
        end
      end
      FMT_BR: begin
        if (armed) begin
          aligned_next                = {CW{sz & pfx_reg[JW-1]}};
          aligned_next[BW-1:0]        = f_br;
          aligned_next[JW+BW-1:BW]    = pfx_reg;
        end else begin
          aligned_next                = {CW{sz & f_br[BW-1]}};
          aligned_next[BW-1:0]        = f_br;
        end
      end
      FMT_JMP: begin
        if (armed) begin
          aligned_next                = {CW{sz & pfx_reg[JW-1]}};
          aligned_next[JW-1:0]        = f_jmp;
          aligned_next[JW+JW-1:JW]    = pfx_reg;
        end else begin
          aligned_next                = {CW{sz & f_jmp[JW-1]}};
          aligned_next[JW-1:0]        = f_jmp;
        end
      end
      default: aligned_next = '0;
    endcase
  end

  imm_ext #(
    .IW (CW),
    .DW (DW)
  ) u_ext (
    .din  (aligned_next),
    .sz   (sz),
    .dout (ext_next)
  );

  // Branch scaling is applied after extension/truncation
  always_comb begin
    imm_next = ext_next;
`ifdef IMM_GEN_BR_SCALE_EN
    if (fmt == FMT_BR) begin
      imm_next = {ext_next[DW-2:0], 1'b0};
    end
`endif
  end

  // State, prefix and output registers; reset beats flush beats en
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pfx_reg   <= '0;
      imm_reg   <= '0;
      vld_reg   <= 1'b0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
      vld_reg   <= 1'b0;
    end else if (en) begin
      if (fmt == FMT_PFX) begin
        pfx_reg   <= f_jmp;
        state_reg <= ST_ARMED;
        vld_reg   <= 1'b0;
      end else begin
        imm_reg   <= imm_next;
        state_reg <= ST_IDLE;
        vld_reg   <= 1'b1;
      end
    end else begin
      vld_reg <= 1'b0;
    end
  end

  assign imm        = imm_reg;
  assign imm_vld    = vld_reg;
  assign pfx_active = armed;

endmodule
